piso_tx_scheduler: RTL and testbench

//  Shares one PISO_Encoder serializer between N_REQ parallel-word requesters.

---
 rtl/piso_tx_scheduler_pkg.sv | 26 ++
 rtl/piso_tx_scheduler_if.sv | 35 +++
 rtl/piso_tx_scheduler_rr_arbiter.sv | 31 +++
 rtl/piso_tx_scheduler.sv | 174 +++++++++++++++++
 tb/tb_piso_tx_scheduler.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_tx_scheduler_pkg.sv
// Shared types and helpers for the PISO transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package piso_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        GAP     = 3'd4
    } state_t;

    localparam int GAP_CYCLES_DEF = 2;

    // Width of a requester index; never below one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default watchdog: a full frame of WIDTH bits at four cycles per bit plus slack.
    function automatic int timeout_def(input int width);
        return 4 * width + 8;
    endfunction

endpackage

// File: rtl/piso_tx_scheduler_if.sv
// Requester-side and serializer-side signals of the PISO transmit scheduler.
// Latency: n/a (wiring only).
// Backpressure: req_valid holds until the one-cycle req_ready pulse; ser_busy stalls the scheduler.
interface piso_tx_scheduler_if
    import piso_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) ();
    localparam int GRANT_W = grant_w(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]       ser_data;
    logic                   ser_trigger;
    logic                   ser_busy;
    logic [GRANT_W-1:0]     grant_id;
    logic                   sched_busy;
    logic                   frame_done;
    logic                   frame_err;

    // Scheduler side.
    modport master (
        input  req_valid, req_data, ser_busy,
        output req_ready, ser_data, ser_trigger, grant_id, sched_busy, frame_done, frame_err
    );

    // Requesters plus serializer side.
    modport slave (
        output req_valid, req_data, ser_busy,
        input  req_ready, ser_data, ser_trigger, grant_id, sched_busy, frame_done, frame_err
    );

endinterface

// File: rtl/piso_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first valid requester at or after the rotating pointer.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is used.
module piso_rr_arbiter
    import piso_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int GRANT_W = grant_w(N_REQ)
) (
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [GRANT_W-1:0] i_rr_ptr,
    output logic [GRANT_W-1:0] o_win,
    output logic               o_any_valid
);

    // Scan from farthest to nearest so the nearest valid index wins.
    always_comb begin
        int w_idx;
        w_idx       = 0;
        o_win       = '0;
        o_any_valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = (int'(i_rr_ptr) + i) % N_REQ;
            if (i_req_valid[w_idx]) begin
                o_win       = GRANT_W'(w_idx);
                o_any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/piso_tx_scheduler.sv
// Shares one PISO serializer among N_REQ requesters with round-robin grants and an inter-frame gap.
// Latency: req_ready 1 cycle after valid seen in IDLE, ser_trigger 1 cycle after req_ready.
// Backpressure: one accept per frame; requests wait while busy. Watchdog under PISO_SCHED_TIMEOUT_EN.
module piso_tx_scheduler
    import piso_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 32,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int TIMEOUT    = timeout_def(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    piso_tx_scheduler_if.master bus
);

    localparam int     GRANT_W     = grant_w(N_REQ);
    localparam int     CNT_W       = $clog2(TIMEOUT + GAP_CYCLES + 2);
    localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GRANT_W-1:0] r_rr_ptr;
    logic [GRANT_W-1:0] r_grant_id;
    logic [WIDTH-1:0]   r_ser_data;
    logic [N_REQ-1:0]   r_req_ready;
    logic               r_ser_trigger;
    logic               r_sched_busy;
    logic               r_frame_done;
    logic [CNT_W-1:0]   r_cnt;

    logic [GRANT_W-1:0] w_win;
    logic               w_any_valid;
    logic               w_accept;
    logic               w_trig_nxt;
    logic               w_done_nxt;
    logic               w_cnt_clr;
    logic               w_cnt_inc;

    piso_rr_arbiter #(
        .N_REQ   (N_REQ),
        .GRANT_W (GRANT_W)
    ) u_arb (
        .i_req_valid (bus.req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_win       (w_win),
        .o_any_valid (w_any_valid)
    );

`ifdef PISO_SCHED_TIMEOUT_EN
    logic r_frame_err;
    logic w_err_nxt;
    logic w_timeout;
    assign w_timeout = (int'(r_cnt) >= TIMEOUT - 1);
`endif

    // Next state plus the one-cycle strobes that get registered on the next edge.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_trig_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
`ifdef PISO_SCHED_TIMEOUT_EN
        w_err_nxt   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_trig_nxt  = 1'b1;
                w_cnt_clr   = 1'b1;
                w_state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.ser_busy) begin
                    w_state_nxt = WAIT_LO;
`ifdef PISO_SCHED_TIMEOUT_EN
                    w_cnt_inc   = 1'b1;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = AFTER_FRAME;
                end else begin
                    w_cnt_inc   = 1'b1;
`endif
                end
            end
            WAIT_LO: begin
                // A genuine end of frame wins over a watchdog expiry in the same cycle.
                if (!bus.ser_busy) begin
                    w_done_nxt  = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = AFTER_FRAME;
`ifdef PISO_SCHED_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = AFTER_FRAME;
                end else begin
                    w_cnt_inc   = 1'b1;
`endif
                end
            end
            GAP: begin
                if (int'(r_cnt) >= GAP_CYCLES - 1) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, grant bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_ser_data    <= '0;
            r_req_ready   <= '0;
            r_ser_trigger <= 1'b0;
            r_sched_busy  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_req_ready   <= '0;
            r_ser_trigger <= w_trig_nxt;
            r_frame_done  <= w_done_nxt;
            r_sched_busy  <= (w_state_nxt != IDLE);
            if (w_accept) begin
                r_ser_data  <= bus.req_data[int'(w_win)*WIDTH +: WIDTH];
                r_grant_id  <= w_win;
                r_req_ready <= N_REQ'(1) << w_win;
                r_rr_ptr    <= (int'(w_win) == N_REQ - 1) ? '0 : w_win + GRANT_W'(1);
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PISO_SCHED_TIMEOUT_EN
    // Watchdog expiry strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err_nxt;
        end
    end
    assign bus.frame_err = r_frame_err;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.req_ready   = r_req_ready;
    assign bus.ser_data    = r_ser_data;
    assign bus.ser_trigger = r_ser_trigger;
    assign bus.grant_id    = r_grant_id;
    assign bus.sched_busy  = r_sched_busy;
    assign bus.frame_done  = r_frame_done;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Directed and randomized checks of piso_tx_scheduler against a round-robin reference model.
// Two instances: inter-frame gap of 2 and gap of 0; outputs of the selected one are checked.
// Optional watchdog section when PISO_SCHED_TIMEOUT_EN is defined.
module tb_piso_tx_scheduler;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int GAP_A = 2;
    localparam int TMO   = 4 * W + 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic           ser_busy;
    bit             sel;

    always #5 clk = ~clk;

    piso_tx_scheduler_if #(.N_REQ(N), .WIDTH(W)) ifa ();
    piso_tx_scheduler_if #(.N_REQ(N), .WIDTH(W)) ifb ();

    assign ifa.req_valid = req_valid;
    assign ifa.req_data  = req_data;
    assign ifa.ser_busy  = ser_busy;
    assign ifb.req_valid = req_valid;
    assign ifb.req_data  = req_data;
    assign ifb.ser_busy  = ser_busy;

    piso_tx_scheduler #(.N_REQ(N), .WIDTH(W), .GAP_CYCLES(GAP_A), .TIMEOUT(TMO)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    piso_tx_scheduler #(.N_REQ(N), .WIDTH(W), .GAP_CYCLES(0), .TIMEOUT(TMO)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    logic [N-1:0] o_ready;
    logic [W-1:0] o_data;
    logic [1:0]   o_gid;
    logic         o_trig, o_sbusy, o_done, o_err;

    assign o_ready = sel ? ifb.req_ready   : ifa.req_ready;
    assign o_data  = sel ? ifb.ser_data    : ifa.ser_data;
    assign o_trig  = sel ? ifb.ser_trigger : ifa.ser_trigger;
    assign o_gid   = sel ? ifb.grant_id    : ifa.grant_id;
    assign o_sbusy = sel ? ifb.sched_busy  : ifa.sched_busy;
    assign o_done  = sel ? ifb.frame_done  : ifa.frame_done;
    assign o_err   = sel ? ifb.frame_err   : ifa.frame_err;

    int           n_assert = 0;
    int           n_fail   = 0;
    int           m_rr;        // model: next requester with top priority
    int           gap;         // gap of the instance under test
    logic [W-1:0] d [N];       // model: word each requester currently offers

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first valid index at or after ptr, wrapping mod N.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic set_word(input int i, input logic [W-1:0] val);
        d[i] = val;
        req_data[i*W +: W] = val;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        ser_busy  = 1'b0;
        for (int i = 0; i < N; i++) set_word(i, $urandom);
        tick();
        chk("rst_ready",   64'(o_ready), 64'd0);
        chk("rst_data",    64'(o_data),  64'd0);
        chk("rst_trigger", 64'(o_trig),  64'd0);
        chk("rst_grant",   64'(o_gid),   64'd0);
        chk("rst_busy",    64'(o_sbusy), 64'd0);
        chk("rst_done",    64'(o_done),  64'd0);
        chk("rst_err",     64'(o_err),   64'd0);
        tick();
        reset = 1'b0;
        m_rr  = 0;
        tick();
    endtask

    // One full frame: offer v, expect the model's winner after exp_lat cycles,
    // emulate a serializer busy for busy_len+1 cycles, raise late_v mid-frame.
    task automatic frame(input logic [N-1:0] v, input int exp_lat, input int busy_len,
                         input logic [N-1:0] late_v, input bit drop_after);
        int           win;
        int           lat;
        logic [W-1:0] held;
        req_valid = v;
        win = pick(v, m_rr);
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) chk("done_one_cycle", 64'(o_done), 64'd0);
        end while (o_ready == '0 && lat < 40);
        chk("accept_latency", 64'(lat), 64'(exp_lat));
        chk("req_ready_onehot", 64'(o_ready), 64'(1) << win);
        chk("ser_data_latched", 64'(o_data), 64'(d[win]));
        chk("grant_id", 64'(o_gid), 64'(win));
        chk("sched_busy_start", 64'(o_sbusy), 64'd1);
        chk("no_trigger_yet", 64'(o_trig), 64'd0);
        m_rr = (win + 1) % N;
        held = d[win];
        if (drop_after) req_valid[win] = 1'b0;
        set_word(win, $urandom);
        tick();
        chk("trigger_pulse", 64'(o_trig), 64'd1);
        chk("ready_one_cycle", 64'(o_ready), 64'd0);
        ser_busy = 1'b1;
        tick();
        chk("trigger_end", 64'(o_trig), 64'd0);
        for (int c = 0; c < busy_len; c++) begin
            if (c == 1) req_valid = req_valid | late_v;
            tick();
            chk("no_accept_in_frame", 64'(o_ready), 64'd0);
            chk("data_hold", 64'(o_data), 64'(held));
            chk("no_early_done", 64'(o_done), 64'd0);
        end
        ser_busy = 1'b0;
        tick();
        chk("frame_done", 64'(o_done), 64'd1);
        chk("no_err", 64'(o_err), 64'd0);
        chk("data_hold_gap", 64'(o_data), 64'(held));
        chk("sched_busy_after", 64'(o_sbusy), 64'(gap > 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] v;
        int           c;
        bit           done_seen;

        // ---- instance with inter-frame gap of 2 ----
        sel = 1'b0;
        gap = GAP_A;
        apply_reset();

        // Single request from requester 2 with a fixed word.
        set_word(2, 32'hA5A5_0F0F);
        frame(4'b0100, 1, 3, 4'b0000, 1'b1);
        chk("single_word", 64'(o_data), 64'hA5A5_0F0F);

        // Fairness: all valid continuously from a fresh pointer.
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            frame(4'b1111, (k == 0) ? 1 : gap + 1, $urandom_range(0, 4), 4'b0000, 1'b0);
            chk("fair_seq", 64'(o_gid), 64'(k % N));
        end

        // Request arriving in WAIT_LO waits for IDLE; a request dropped before IDLE is ignored.
        apply_reset();
        frame(4'b0010, 1, 4, 4'b1000, 1'b1);
        frame(4'b1000, gap + 1, 2, 4'b0000, 1'b1);
        frame(4'b0001, gap + 1, 3, 4'b0010, 1'b1);
        frame(4'b0100, gap + 1, 1, 4'b0000, 1'b1);
        chk("dropped_req_skipped", 64'(o_gid), 64'd2);

        // Randomized traffic against the model.
        for (int k = 0; k < 10; k++) begin
            v = 4'($urandom_range(1, 15));
            frame(v, gap + 1, $urandom_range(0, 5), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Reset while the serializer is busy.
        apply_reset();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        ser_busy = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_ready",   64'(o_ready), 64'd0);
        chk("midrst_data",    64'(o_data),  64'd0);
        chk("midrst_trigger", 64'(o_trig),  64'd0);
        chk("midrst_grant",   64'(o_gid),   64'd0);
        chk("midrst_busy",    64'(o_sbusy), 64'd0);
        chk("midrst_done",    64'(o_done),  64'd0);
        ser_busy = 1'b0;
        tick();
        reset = 1'b0;
        m_rr  = 0;
        frame(4'b1001, 1, 2, 4'b0000, 1'b1);
        chk("post_reset_grant0", 64'(o_gid), 64'd0);

`ifdef PISO_SCHED_TIMEOUT_EN
        // Serializer never answers: watchdog fires TIMEOUT cycles after the trigger.
        apply_reset();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        m_rr = 3;
        tick();
        chk("tmo_trigger", 64'(o_trig), 64'd1);
        c = 0;
        done_seen = 1'b0;
        do begin
            tick();
            c++;
            if (o_done) done_seen = 1'b1;
        end while (!o_err && c < TMO + 20);
        chk("tmo_latency", 64'(c), 64'(TMO));
        chk("tmo_no_done", 64'(done_seen), 64'd0);
        frame(4'b0001, gap + 1, 2, 4'b0000, 1'b1);
        chk("tmo_recover_grant", 64'(o_gid), 64'd0);
`else
        c = 0;
        done_seen = 1'b0;
`endif

        // ---- instance with no inter-frame gap ----
        sel = 1'b1;
        gap = 0;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            frame(4'b0011, 1, $urandom_range(0, 3), 4'b0000, 1'b0);
            chk("gap0_seq", 64'(o_gid), 64'(k % 2));
        end
        for (int k = 0; k < 6; k++) begin
            v = 4'($urandom_range(1, 15));
            frame(v, 1, $urandom_range(0, 4), 4'b0000, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
